pcileech_cfgspace_shadow: RTL and testbench
===========================================

Name: pcileech_cfgspace_shadow

Overview:
- 4 KB PCIe configuration-space shadow: 1024 x 32-bit dual-port block RAM between the PCIe core's extended-configuration interface (port A) and internal host/controller logic (port B).
- Port A serves cfg_ext reads and applies writes only to bits enabled by a per-register overlay write mask.
- Port B gives the host unrestricted read/write access so it can preload or inspect the emulated configuration space.

Parameters:
- INIT_FILE, "", hex file ($readmemh) for initial RAM contents; empty means all-zero.
- OVL_IDX, {10'h3FF,10'h00F,10'h004,10'h001}, four packed 10-bit dword indices of overlay registers; entry 0 is the LSB field.
- OVL_MASK, {32'h0,32'h0000_00FF,32'hFFFF_F000,32'hFFFF_FFFF}, four packed 32-bit writable-bit masks matching OVL_IDX; a zero mask disables its entry.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cfg_ext_read_received  in  1  PCIe config read request strobe
- cfg_ext_write_received  in  1  PCIe config write request strobe
- cfg_ext_register_number  in  10  dword index (byte offset >> 2)
- cfg_ext_function_number  in  4  PCIe function number
- cfg_ext_write_data  in  32  PCIe write data
- cfg_ext_write_byte_enable  in  4  per-byte write enables; bit n enables bits 8n+7:8n
- cfg_ext_read_data  out  32  PCIe read data
- cfg_ext_read_data_valid  out  1  one-cycle read-data strobe
- host_access_en  in  1  host port enable
- host_write_en  in  1  host write (1) / read (0) when enabled
- host_addr  in  12  host byte address; bits 1:0 ignored
- host_write_data  in  32  host write data
- host_read_data  out  32  host read data

Behaviour:
- The only clock is clk. reset_n is asynchronous and active-low.
- Reset clears cfg_ext_read_data, cfg_ext_read_data_valid and host_read_data to 0. RAM contents are not cleared. Reset in the middle of a read drops the pending valid.
- PCIe read:
  - cfg_ext_read_received sampled high at edge N gives cfg_ext_read_data = RAM[cfg_ext_register_number] after edge N+1, with cfg_ext_read_data_valid high for exactly that one cycle.
  - cfg_ext_read_data holds its value until the next read completes.
  - Back-to-back reads on consecutive cycles are fully pipelined.
- PCIe write, on the edge where cfg_ext_write_received is high:
  - m = overlay mask for the index (0 if the index matches no enabled entry) AND the byte-enable expansion.
  - RAM[idx] <= (RAM[idx] & ~m) | (cfg_ext_write_data & m).
  - A non-overlay register, or byte_enable = 0, leaves RAM unchanged and produces no error.
  - Overlay lookup is combinational over the 4 entries. If one index appears in several entries, the masks are ORed.
- Function number: only function 0 is backed.
  - A non-zero function read returns 32'h0 with the normal valid pulse.
  - A non-zero function write is ignored.
- Simultaneous PCIe read and write in one cycle: both are performed. The read returns the pre-write contents (read-first).
- Host port, on the edge where host_access_en is high:
  - host_write_en = 1: RAM[host_addr[11:2]] <= host_write_data. All 32 bits are written and the overlay mask is not applied.
  - host_write_en = 0: host_read_data = RAM[host_addr[11:2]] one cycle later, read-first; it holds until the next host read.
  - Host writes do not update host_read_data.
- Collisions:
  - PCIe and host writes to the same dword in the same cycle: the host write wins completely.
  - A read on either port that collides with a write on the other port in the same cycle returns the old data.
- Strobes are level-sampled every cycle; there is no handshake and no backpressure.

Test Plan:
- Reset, host write 0x004 = 32'h12345678, then host read 0x004 -> host_read_data = 12345678 one cycle after the read edge.
- PCIe read reg 0x001, function 0 -> one-cycle valid pulse with data 12345678. Write 87654321 with BE=F, read back -> 87654321.
- PCIe write 32'hAABBCCDD with BE=4'h5 to reg 0x001, read back -> 87BB43DD.
- PCIe read reg 0x010 (zero init) -> 0. Write 11223344 with BE=F to reg 0x010, read back -> still 0 (non-overlay).
- Overlay masks: write FFFFFFFF to reg 0x004 via PCIe -> reads FFFFF000. Function 1 read of reg 0x001 -> 0 with valid. Function 1 write of reg 0x001 -> no change.
- Assert reset_n low while a read is pending -> valid and data outputs go to 0 immediately and no valid pulse follows. Same-cycle host and PCIe writes to reg 0x001 -> the host value is stored.

Source files
------------

// File: rtl/pcileech_cfgspace_shadow_if.sv
// Bus bundle between the PCIe core's cfg_ext interface plus the host port
// and the configuration-space shadow. The slave modport is the shadow side.
interface pcileech_cfgspace_shadow_if;
  logic        cfg_ext_read_received;
  logic        cfg_ext_write_received;
  logic [9:0]  cfg_ext_register_number;
  logic [3:0]  cfg_ext_function_number;
  logic [31:0] cfg_ext_write_data;
  logic [3:0]  cfg_ext_write_byte_enable;
  logic [31:0] cfg_ext_read_data;
  logic        cfg_ext_read_data_valid;
  logic        host_access_en;
  logic        host_write_en;
  logic [11:0] host_addr;
  logic [31:0] host_write_data;
  logic [31:0] host_read_data;

  modport slave (
    input  cfg_ext_read_received, cfg_ext_write_received, cfg_ext_register_number,
    input  cfg_ext_function_number, cfg_ext_write_data, cfg_ext_write_byte_enable,
    input  host_access_en, host_write_en, host_addr, host_write_data,
    output cfg_ext_read_data, cfg_ext_read_data_valid, host_read_data
  );

  modport master (
    output cfg_ext_read_received, cfg_ext_write_received, cfg_ext_register_number,
    output cfg_ext_function_number, cfg_ext_write_data, cfg_ext_write_byte_enable,
    output host_access_en, host_write_en, host_addr, host_write_data,
    input  cfg_ext_read_data, cfg_ext_read_data_valid, host_read_data
  );
endinterface

// File: rtl/pcileech_cfgspace_shadow.sv
// 4 KB PCIe configuration-space shadow (1024 x 32-bit dual-port RAM).
// Port A: cfg_ext reads (two-edge latency) and overlay-masked writes.
// Port B: unrestricted host read/write used to preload or inspect the space.
module pcileech_cfgspace_shadow #(
  parameter string        INIT_FILE = "",
  parameter logic [39:0]  OVL_IDX   = {10'h3FF, 10'h00F, 10'h004, 10'h001},
  parameter logic [127:0] OVL_MASK  = {32'h0000_0000, 32'h0000_00FF, 32'hFFFF_F000, 32'hFFFF_FFFF}
) (
  input  logic                          clk,
  input  logic                          reset_n,
  pcileech_cfgspace_shadow_if.slave     bus
);

  // Writable-bit mask for a dword index; duplicate entries OR together.
  function automatic logic [31:0] ovl_mask_f(input logic [9:0] idx);
    logic [31:0] m;
    m = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      if (OVL_IDX[i*10 +: 10] == idx) begin
        m = m | OVL_MASK[i*32 +: 32];
      end
    end
    return m;
  endfunction

  // Expand per-byte enables into a per-bit mask.
  function automatic logic [31:0] be_expand_f(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  logic [31:0] mem [0:1023];

  logic [9:0]  a_idx_s;
  logic        a_func0_s;
  logic [31:0] a_mask_s;
  logic [31:0] a_old_s;
  logic [31:0] a_wdata_s;
  logic        a_we_s;
  logic [9:0]  b_idx_s;
  logic        b_we_s;
  logic        b_re_s;
  logic        unused_s;

  logic        rd_pend_r;
  logic [31:0] rd_hold_r;
  logic [31:0] cfg_rd_data_r;
  logic        cfg_rd_valid_r;
  logic [31:0] host_rd_data_r;

  assign unused_s = ^bus.host_addr[1:0];

  // Decode both ports and build the masked read-modify-write value for port A.
  always_comb begin
    a_idx_s   = bus.cfg_ext_register_number;
    a_func0_s = (bus.cfg_ext_function_number == 4'd0);
    a_mask_s  = ovl_mask_f(a_idx_s) & be_expand_f(bus.cfg_ext_write_byte_enable);
    a_old_s   = mem[a_idx_s];
    a_wdata_s = (a_old_s & ~a_mask_s) | (bus.cfg_ext_write_data & a_mask_s);
    a_we_s    = bus.cfg_ext_write_received && a_func0_s && (a_mask_s != 32'h0000_0000);
    b_idx_s   = bus.host_addr[11:2];
    b_we_s    = bus.host_access_en && bus.host_write_en;
    b_re_s    = bus.host_access_en && !bus.host_write_en;
  end

  // RAM write ports; the host assignment comes last so it wins a same-dword collision.
  always_ff @(posedge clk) begin
    if (a_we_s) begin
      mem[a_idx_s] <= a_wdata_s;
    end
    if (b_we_s) begin
      mem[b_idx_s] <= bus.host_write_data;
    end
  end

  // PCIe read pipeline: capture pre-write data on the request edge, present it one edge later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_r      <= 1'b0;
      rd_hold_r      <= 32'h0000_0000;
      cfg_rd_valid_r <= 1'b0;
      cfg_rd_data_r  <= 32'h0000_0000;
    end else begin
      rd_pend_r      <= bus.cfg_ext_read_received;
      if (bus.cfg_ext_read_received) begin
        rd_hold_r <= a_func0_s ? mem[a_idx_s] : 32'h0000_0000;
      end
      cfg_rd_valid_r <= rd_pend_r;
      if (rd_pend_r) begin
        cfg_rd_data_r <= rd_hold_r;
      end
    end
  end

  // Host read port: read-first, holds until the next host read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      host_rd_data_r <= 32'h0000_0000;
    end else if (b_re_s) begin
      host_rd_data_r <= mem[b_idx_s];
    end
  end

  assign bus.cfg_ext_read_data       = cfg_rd_data_r;
  assign bus.cfg_ext_read_data_valid = cfg_rd_valid_r;
  assign bus.host_read_data          = host_rd_data_r;

endmodule

// File: tb/tb_pcileech_cfgspace_shadow.sv
// Self-checking bench for pcileech_cfgspace_shadow: directed scenarios plus a
// randomized run against a bit-level behavioural model of the shadow space.
module tb_pcileech_cfgspace_shadow;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pcileech_cfgspace_shadow_if bus ();
  pcileech_cfgspace_shadow dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  logic [31:0] model [1024];
  logic [9:0]  ovl_idx_t  [4] = '{10'h001, 10'h004, 10'h00F, 10'h3FF};
  logic [31:0] ovl_mask_t [4] = '{32'hFFFF_FFFF, 32'hFFFF_F000, 32'h0000_00FF, 32'h0000_0000};

  // A bit is writable if its byte is enabled and some overlay entry for idx allows it.
  function automatic void model_pcie_write(input logic [9:0] idx, input logic [3:0] func,
                                           input logic [31:0] d, input logic [3:0] be);
    if (func != 4'd0) return;
    for (int b = 0; b < 32; b++) begin
      bit wr;
      wr = 1'b0;
      for (int e = 0; e < 4; e++)
        if (ovl_idx_t[e] == idx && ovl_mask_t[e][b] && be[b/8]) wr = 1'b1;
      if (wr) model[idx][b] = d[b];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cfg_ext_read_received     = 1'b0;
    bus.cfg_ext_write_received    = 1'b0;
    bus.cfg_ext_register_number   = 10'd0;
    bus.cfg_ext_function_number   = 4'd0;
    bus.cfg_ext_write_data        = 32'h0;
    bus.cfg_ext_write_byte_enable = 4'h0;
    bus.host_access_en            = 1'b0;
    bus.host_write_en             = 1'b0;
    bus.host_addr                 = 12'h000;
    bus.host_write_data           = 32'h0;
  endtask

  task automatic host_write(input logic [11:0] a, input logic [31:0] d);
    bus.host_access_en = 1'b1; bus.host_write_en = 1'b1;
    bus.host_addr = a; bus.host_write_data = d;
    tick();
    bus.host_access_en = 1'b0; bus.host_write_en = 1'b0;
    model[a[11:2]] = d;
  endtask

  task automatic host_read(input logic [11:0] a, output logic [31:0] d);
    bus.host_access_en = 1'b1; bus.host_write_en = 1'b0; bus.host_addr = a;
    tick();
    d = bus.host_read_data;
    bus.host_access_en = 1'b0;
  endtask

  task automatic pcie_write(input logic [9:0] idx, input logic [3:0] func,
                            input logic [31:0] d, input logic [3:0] be);
    bus.cfg_ext_write_received = 1'b1; bus.cfg_ext_register_number = idx;
    bus.cfg_ext_function_number = func; bus.cfg_ext_write_data = d;
    bus.cfg_ext_write_byte_enable = be;
    tick();
    bus.cfg_ext_write_received = 1'b0;
    model_pcie_write(idx, func, d, be);
  endtask

  task automatic pcie_read(input logic [9:0] idx, input logic [3:0] func, output logic [31:0] d,
                           output logic v_early, output logic v_data, output logic v_after);
    bus.cfg_ext_read_received = 1'b1; bus.cfg_ext_register_number = idx;
    bus.cfg_ext_function_number = func;
    tick();
    bus.cfg_ext_read_received = 1'b0;
    v_early = bus.cfg_ext_read_data_valid;
    tick();
    v_data = bus.cfg_ext_read_data_valid;
    d = bus.cfg_ext_read_data;
    tick();
    v_after = bus.cfg_ext_read_data_valid;
  endtask

  task automatic test_reset();
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.cfg_ext_read_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data: got %h want 00000000", bus.cfg_ext_read_data); end
    checks++; if (bus.cfg_ext_read_data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.cfg_ext_read_data_valid); end
    checks++; if (bus.host_read_data !== 32'h0) begin failures++; $display("FAIL reset_host_rd: got %h want 00000000", bus.host_read_data); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_host_rw();
    logic [31:0] d;
    host_write(12'h004, 32'h1234_5678);
    host_read(12'h004, d);
    checks++; if (d !== 32'h1234_5678) begin failures++; $display("FAIL host_read: got %h want 12345678", d); end
    host_write(12'h008, 32'hDEAD_BEEF);
    checks++; if (bus.host_read_data !== 32'h1234_5678) begin failures++; $display("FAIL host_hold: got %h want 12345678", bus.host_read_data); end
    host_read(12'h007, d);
    checks++; if (d !== 32'h1234_5678) begin failures++; $display("FAIL host_addr_lsb: got %h want 12345678", d); end
  endtask

  task automatic test_pcie_rw();
    logic [31:0] d; logic ve, vd, va;
    pcie_read(10'h001, 4'd0, d, ve, vd, va);
    checks++; if ({ve, vd, va} !== 3'b010) begin failures++; $display("FAIL read_valid_pulse: got %b want 010", {ve, vd, va}); end
    checks++; if (d !== 32'h1234_5678) begin failures++; $display("FAIL read_reg1: got %h want 12345678", d); end
    tick();
    checks++; if (bus.cfg_ext_read_data !== 32'h1234_5678) begin failures++; $display("FAIL read_hold: got %h want 12345678", bus.cfg_ext_read_data); end
    pcie_write(10'h001, 4'd0, 32'h8765_4321, 4'hF);
    pcie_read(10'h001, 4'd0, d, ve, vd, va);
    checks++; if (d !== 32'h8765_4321 || vd !== 1'b1) begin failures++; $display("FAIL write_full: got %h/%b want 87654321/1", d, vd); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d; logic ve, vd, va;
    pcie_write(10'h001, 4'd0, 32'hAABB_CCDD, 4'h5);
    pcie_read(10'h001, 4'd0, d, ve, vd, va);
    checks++; if (d !== 32'h87BB_43DD) begin failures++; $display("FAIL byte_enable: got %h want 87BB43DD", d); end
    pcie_write(10'h001, 4'd0, 32'h0000_0000, 4'h0);
    pcie_read(10'h001, 4'd0, d, ve, vd, va);
    checks++; if (d !== 32'h87BB_43DD) begin failures++; $display("FAIL byte_enable_zero: got %h want 87BB43DD", d); end
  endtask

  task automatic test_non_overlay();
    logic [31:0] d; logic ve, vd, va;
    pcie_read(10'h010, 4'd0, d, ve, vd, va);
    checks++; if (d !== 32'h0 || vd !== 1'b1) begin failures++; $display("FAIL zero_init: got %h/%b want 00000000/1", d, vd); end
    pcie_write(10'h010, 4'd0, 32'h1122_3344, 4'hF);
    pcie_read(10'h010, 4'd0, d, ve, vd, va);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL non_overlay: got %h want 00000000", d); end
  endtask

  task automatic test_overlay_func();
    logic [31:0] d; logic ve, vd, va;
    pcie_write(10'h004, 4'd0, 32'hFFFF_FFFF, 4'hF);
    pcie_read(10'h004, 4'd0, d, ve, vd, va);
    checks++; if (d !== 32'hFFFF_F000) begin failures++; $display("FAIL overlay_mask: got %h want FFFFF000", d); end
    pcie_write(10'h00F, 4'd0, 32'hCAFE_BABE, 4'hF);
    pcie_read(10'h00F, 4'd0, d, ve, vd, va);
    checks++; if (d !== 32'h0000_00BE) begin failures++; $display("FAIL overlay_lowbyte: got %h want 000000BE", d); end
    pcie_read(10'h001, 4'd1, d, ve, vd, va);
    checks++; if (d !== 32'h0 || {ve, vd, va} !== 3'b010) begin failures++; $display("FAIL func1_read: got %h/%b want 00000000/010", d, {ve, vd, va}); end
    pcie_write(10'h001, 4'd1, 32'h0BAD_F00D, 4'hF);
    pcie_read(10'h001, 4'd0, d, ve, vd, va);
    checks++; if (d !== 32'h87BB_43DD) begin failures++; $display("FAIL func1_write: got %h want 87BB43DD", d); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] idx [4];
    logic [31:0] exp [4];
    idx = '{10'h001, 10'h004, 10'h010, 10'h00F};
    for (int i = 0; i < 4; i++) exp[i] = model[idx[i]];
    for (int i = 0; i < 4; i++) begin
      bus.cfg_ext_read_received = 1'b1; bus.cfg_ext_register_number = idx[i];
      bus.cfg_ext_function_number = 4'd0;
      tick();
      if (i >= 1) begin
        checks++; if (bus.cfg_ext_read_data_valid !== 1'b1 || bus.cfg_ext_read_data !== exp[i-1]) begin
          failures++; $display("FAIL back_to_back_%0d: got %h/%b want %h/1", i - 1, bus.cfg_ext_read_data, bus.cfg_ext_read_data_valid, exp[i-1]);
        end
      end
    end
    bus.cfg_ext_read_received = 1'b0;
    tick();
    checks++; if (bus.cfg_ext_read_data_valid !== 1'b1 || bus.cfg_ext_read_data !== exp[3]) begin
      failures++; $display("FAIL back_to_back_3: got %h/%b want %h/1", bus.cfg_ext_read_data, bus.cfg_ext_read_data_valid, exp[3]);
    end
    tick();
  endtask

  task automatic test_reset_midread();
    bus.cfg_ext_read_received = 1'b1; bus.cfg_ext_register_number = 10'h001;
    bus.cfg_ext_function_number = 4'd0;
    tick();
    bus.cfg_ext_read_received = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checks++; if (bus.cfg_ext_read_data_valid !== 1'b0 || bus.cfg_ext_read_data !== 32'h0 || bus.host_read_data !== 32'h0) begin
      failures++; $display("FAIL reset_midread_clear: got %h/%b/%h want 00000000/0/00000000", bus.cfg_ext_read_data, bus.cfg_ext_read_data_valid, bus.host_read_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.cfg_ext_read_data_valid !== 1'b0) begin failures++; $display("FAIL reset_midread_novalid_%0d: got %b want 0", i, bus.cfg_ext_read_data_valid); end
    end
  endtask

  task automatic test_collision();
    logic [31:0] d; logic ve, vd, va; logic [31:0] old;
    bus.host_access_en = 1'b1; bus.host_write_en = 1'b1; bus.host_addr = 12'h004;
    bus.host_write_data = 32'h5A5A_1234;
    bus.cfg_ext_write_received = 1'b1; bus.cfg_ext_register_number = 10'h001;
    bus.cfg_ext_function_number = 4'd0; bus.cfg_ext_write_data = 32'hFFFF_0000;
    bus.cfg_ext_write_byte_enable = 4'hF;
    tick();
    idle_inputs();
    model[1] = 32'h5A5A_1234;
    pcie_read(10'h001, 4'd0, d, ve, vd, va);
    checks++; if (d !== 32'h5A5A_1234) begin failures++; $display("FAIL collision_host_wins: got %h want 5A5A1234", d); end
    old = model[1];
    bus.host_access_en = 1'b1; bus.host_write_en = 1'b0; bus.host_addr = 12'h004;
    bus.cfg_ext_write_received = 1'b1; bus.cfg_ext_register_number = 10'h001;
    bus.cfg_ext_write_data = 32'h0F0F_0F0F; bus.cfg_ext_write_byte_enable = 4'hF;
    bus.cfg_ext_read_received = 1'b1;
    tick();
    idle_inputs();
    model_pcie_write(10'h001, 4'd0, 32'h0F0F_0F0F, 4'hF);
    checks++; if (bus.host_read_data !== old) begin failures++; $display("FAIL collision_host_read_old: got %h want %h", bus.host_read_data, old); end
    tick();
    checks++; if (bus.cfg_ext_read_data !== old) begin failures++; $display("FAIL collision_pcie_read_first: got %h want %h", bus.cfg_ext_read_data, old); end
    tick();
  endtask

  function automatic logic [9:0] pick_idx();
    case ($urandom_range(0, 6))
      0: return 10'h001;
      1: return 10'h004;
      2: return 10'h00F;
      3: return 10'h3FF;
      4: return 10'h010;
      5: return 10'h002;
      default: return 10'($urandom_range(0, 1023));
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] d; logic ve, vd, va;
    logic [31:0] exp_data, exp_host, pend_data, rd_val, hr_val;
    logic pend, exp_valid;
    int errs;
    pcie_read(10'h001, 4'd0, d, ve, vd, va);
    exp_data = model[1];
    host_read(12'h004, d);
    exp_host = model[1];
    pend = 1'b0; pend_data = 32'h0; errs = 0;
    for (int c = 0; c < 400; c++) begin
      logic rd, wr, hen, hwe;
      logic [9:0] ridx, widx, hidx;
      logic [3:0] rfunc, wfunc, be;
      logic [31:0] wd, hd;
      rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
      hen = 1'($urandom_range(0, 1)); hwe = 1'($urandom_range(0, 1));
      ridx = pick_idx(); widx = pick_idx(); hidx = pick_idx();
      rfunc = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      wfunc = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      be = 4'($urandom_range(0, 15)); wd = $urandom; hd = $urandom;
      if ($urandom_range(0, 3) == 0) ridx = widx;
      if ($urandom_range(0, 3) == 0) hidx = widx;
      // Pairs of cfg_ext read and write share one register-number bus.
      if (rd && wr) ridx = widx;
      if (rd && wr) rfunc = wfunc;
      bus.cfg_ext_read_received = rd; bus.cfg_ext_write_received = wr;
      bus.cfg_ext_register_number = wr ? widx : ridx;
      bus.cfg_ext_function_number = wr ? wfunc : rfunc;
      bus.cfg_ext_write_data = wd; bus.cfg_ext_write_byte_enable = be;
      bus.host_access_en = hen; bus.host_write_en = hwe;
      bus.host_addr = {hidx, 2'(($urandom_range(0, 3)))}; bus.host_write_data = hd;
      rd_val = (rfunc != 4'd0) ? 32'h0 : model[ridx];
      hr_val = model[hidx];
      if (wr) model_pcie_write(widx, wfunc, wd, be);
      if (hen && hwe) model[hidx] = hd;
      exp_valid = pend;
      if (pend) exp_data = pend_data;
      pend = rd; pend_data = rd_val;
      if (hen && !hwe) exp_host = hr_val;
      tick();
      checks++; if (bus.cfg_ext_read_data_valid !== exp_valid) begin failures++; errs++; if (errs < 10) $display("FAIL rand_valid cyc %0d: got %b want %b", c, bus.cfg_ext_read_data_valid, exp_valid); end
      checks++; if (bus.cfg_ext_read_data !== exp_data) begin failures++; errs++; if (errs < 10) $display("FAIL rand_rd_data cyc %0d: got %h want %h", c, bus.cfg_ext_read_data, exp_data); end
      checks++; if (bus.host_read_data !== exp_host) begin failures++; errs++; if (errs < 10) $display("FAIL rand_host_data cyc %0d: got %h want %h", c, bus.host_read_data, exp_host); end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;
    idle_inputs();
    test_reset();
    test_host_rw();
    test_pcie_rw();
    test_byte_enable();
    test_non_overlay();
    test_overlay_func();
    test_back_to_back();
    test_reset_midread();
    test_collision();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
